// File: rtl/ahb_fifo_pkg.sv
// ahb_fifo_pkg: payload width and pointer sizing shared by the FIFO controller and entry cells.
package ahb_fifo_pkg;

  localparam int FIFO_DW = 55;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ahb_fifo_ptr.sv
// ahb_fifo_ptr: index pointer with an extra wrap bit; wraps modulo 2*DEPTH.
module ahb_fifo_ptr #(
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [PTR_W:0]   o_ptr
);

  logic [PTR_W:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ptr <= '0;
    else if (i_inc) r_ptr <= r_ptr + 1'b1;
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/ahb_fifo_ctrl.sv
// ahb_fifo_ctrl: pointers, flow control, read mux and status for the AHB request FIFO.
// Storage lives in external entry cells written through the one-hot create_en.
module ahb_fifo_ctrl
  import ahb_fifo_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int DW       = FIFO_DW,
  parameter int AFULL_TH = 6,
  localparam int PTR_W   = ptr_w(DEPTH)
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_rst,
  input  logic                  push_vld,
  output logic                  push_rdy,
  input  logic [DW-1:0]         push_data,
  output logic [DEPTH-1:0]      entry_create_en,
  output logic [DW-1:0]         entry_data_in,
  input  logic [DEPTH*DW-1:0]   entry_data_out,
  output logic                  pop_vld,
  input  logic                  pop_rdy,
  output logic [DW-1:0]         pop_data,
  output logic [PTR_W:0]        count,
  output logic                  almost_full,
  output logic                  ovf_err,
  output logic                  unf_err,
  input  logic                  err_clr
);

  logic [PTR_W:0] w_wr_ptr;
  logic [PTR_W:0] w_rd_ptr;
  logic [PTR_W:0] r_count;
  logic           r_ovf;
  logic           r_unf;
  logic           w_full;
  logic           w_empty;
  logic           w_push_fire;
  logic           w_pop_fire;

  ahb_fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clk   (fifo_clk),
    .rst   (fifo_rst),
    .i_inc (w_push_fire),
    .o_ptr (w_wr_ptr)
  );

  ahb_fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clk   (fifo_clk),
    .rst   (fifo_rst),
    .i_inc (w_pop_fire),
    .o_ptr (w_rd_ptr)
  );

  assign w_empty = w_wr_ptr == w_rd_ptr;
  assign w_full  = w_wr_ptr == {~w_rd_ptr[PTR_W], w_rd_ptr[PTR_W-1:0]};

  assign push_rdy = ~w_full;
  assign pop_vld  = ~w_empty;

  // Fires are masked by reset so no entry gets a write strobe while reset is held.
  assign w_push_fire = push_vld & push_rdy & ~fifo_rst;
  assign w_pop_fire  = pop_vld & pop_rdy & ~fifo_rst;

  assign entry_create_en = w_push_fire ? DEPTH'(1) << w_wr_ptr[PTR_W-1:0] : '0;
  assign entry_data_in   = push_data;
  assign pop_data        = entry_data_out[DW*int'(w_rd_ptr[PTR_W-1:0]) +: DW];

  assign count       = r_count;
  assign almost_full = r_count >= (PTR_W+1)'(AFULL_TH);
  assign ovf_err     = r_ovf;
  assign unf_err     = r_unf;

  // A new error in the same cycle as err_clr wins over the clear.
  always_ff @(posedge fifo_clk or posedge fifo_rst) begin
    if (fifo_rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= r_count + (PTR_W+1)'(w_push_fire) - (PTR_W+1)'(w_pop_fire);
      r_ovf   <= (push_vld & w_full) | (r_ovf & ~err_clr);
      r_unf   <= (pop_rdy & w_empty) | (r_unf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_ahb_fifo_ctrl.sv
// tb_ahb_fifo_ctrl: randomized scoreboard bench with a queue-based reference model and entry cell model.
module tb_ahb_fifo_ctrl;

  localparam int DEPTH    = 8;
  localparam int DW       = 55;
  localparam int AFULL_TH = 6;

  logic                fifo_clk;
  logic                fifo_rst;
  logic                push_vld;
  logic                push_rdy;
  logic [DW-1:0]       push_data;
  logic [DEPTH-1:0]    entry_create_en;
  logic [DW-1:0]       entry_data_in;
  logic [DEPTH*DW-1:0] entry_data_out;
  logic                pop_vld;
  logic                pop_rdy;
  logic [DW-1:0]       pop_data;
  logic [3:0]          count;
  logic                almost_full;
  logic                ovf_err;
  logic                unf_err;
  logic                err_clr;

  int n_chk  = 0;
  int n_fail = 0;

  ahb_fifo_ctrl #(.DEPTH(DEPTH), .DW(DW), .AFULL_TH(AFULL_TH)) dut (
    .fifo_clk        (fifo_clk),
    .fifo_rst        (fifo_rst),
    .push_vld        (push_vld),
    .push_rdy        (push_rdy),
    .push_data       (push_data),
    .entry_create_en (entry_create_en),
    .entry_data_in   (entry_data_in),
    .entry_data_out  (entry_data_out),
    .pop_vld         (pop_vld),
    .pop_rdy         (pop_rdy),
    .pop_data        (pop_data),
    .count           (count),
    .almost_full     (almost_full),
    .ovf_err         (ovf_err),
    .unf_err         (unf_err),
    .err_clr         (err_clr)
  );

  initial fifo_clk = 1'b0;
  always #5 fifo_clk = ~fifo_clk;

  // External entry cells: each captures the broadcast data on its create strobe.
  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  always @(posedge fifo_clk)
    for (int i = 0; i < DEPTH; i++)
      if (entry_create_en[i]) mem[i] <= entry_data_in;
  always_comb
    for (int i = 0; i < DEPTH; i++) entry_data_out[i*DW +: DW] = mem[i];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an ordered list of stored payloads plus push count and sticky flags.
  logic [DW-1:0] mq [$];
  int  wr_n  = 0;
  bit  m_ovf = 0;
  bit  m_unf = 0;

  always @(negedge fifo_clk) begin
    bit full, empty, pf, qf;
    logic [63:0] exp_ce;
    if (fifo_rst) begin
      mq.delete();
      wr_n  = 0;
      m_ovf = 0;
      m_unf = 0;
    end
    full   = mq.size() == DEPTH;
    empty  = mq.size() == 0;
    pf     = push_vld && !full && !fifo_rst;
    qf     = pop_rdy && !empty && !fifo_rst;
    exp_ce = pf ? (64'd1 << (wr_n % DEPTH)) : 64'd0;
    chk("push_rdy", 64'(push_rdy), 64'(!full));
    chk("pop_vld", 64'(pop_vld), 64'(!empty));
    chk("count", 64'(count), 64'(mq.size()));
    chk("almost_full", 64'(almost_full), 64'(mq.size() >= AFULL_TH));
    chk("create_en", 64'(entry_create_en), exp_ce);
    chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
    chk("unf_err", 64'(unf_err), 64'(m_unf));
    if (pf) chk("data_in", 64'(entry_data_in), 64'(push_data));
    if (!empty) chk("pop_data", 64'(pop_data), 64'(mq[0]));
    if (!fifo_rst) begin
      m_ovf = (push_vld && full) || (m_ovf && !err_clr);
      m_unf = (pop_rdy && empty) || (m_unf && !err_clr);
      if (qf) void'(mq.pop_front());
      if (pf) begin
        mq.push_back(push_data);
        wr_n++;
      end
    end
  end

  task automatic cyc(input logic pv, input logic pr, input logic ec, input logic [DW-1:0] d);
    push_vld  = pv;
    pop_rdy   = pr;
    err_clr   = ec;
    push_data = d;
    @(posedge fifo_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom, $urandom});
  endfunction

  initial begin
    fifo_rst  = 1'b1;
    push_vld  = 1'b0;
    pop_rdy   = 1'b0;
    err_clr   = 1'b0;
    push_data = '0;
    repeat (2) @(posedge fifo_clk);
    #1;
    fifo_rst = 1'b0;
    repeat (2) cyc(0, 0, 0, '0);
    cyc(1, 0, 0, DW'(64'hA5));
    repeat (2) cyc(0, 1, 0, '0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 0, DW'(64'h100 + i));
    repeat (2) cyc(1, 0, 0, DW'(64'hDEAD));
    repeat (12) cyc(1, 1, 0, rnd());
    cyc(0, 0, 1, '0);
    repeat (9) cyc(0, 1, 0, '0);
    cyc(0, 0, 1, '0);
    cyc(0, 0, 0, '0);
    cyc(0, 1, 1, '0);
    cyc(0, 0, 1, '0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, rnd());
    fifo_rst = 1'b1;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_push_rdy", 64'(push_rdy), 64'd1);
    chk("rst_pop_vld", 64'(pop_vld), 64'd0);
    push_vld = 1'b1;
    #1;
    chk("rst_create_en", 64'(entry_create_en), 64'd0);
    push_vld = 1'b0;
    @(posedge fifo_clk);
    #1;
    fifo_rst = 1'b0;
    cyc(1, 0, 0, DW'(64'h77));
    cyc(0, 1, 0, '0);
    for (int i = 0; i < 2000; i++)
      cyc(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
          1'($urandom_range(0, 99) < 5), rnd());
    cyc(0, 0, 0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
